// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared opcode, command and state types for the vector list sequencer
package vector_pkg;

  localparam int VEC_COORD_W = 8;
  localparam int CMD_WIDTH   = 2 + 2 * VEC_COORD_W;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_POS  = 2'b01,
    OP_DRAW = 2'b10,
    OP_END  = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e                op;
    logic [VEC_COORD_W-1:0] x;
    logic [VEC_COORD_W-1:0] y;
  } vector_cmd_t;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_FETCH     = 5'b00010,
    S_DECODE    = 5'b00100,
    S_WAIT_DONE = 5'b01000,
    S_FRAME_END = 5'b10000
  } seq_state_e;

endpackage

// File: rtl/vector_list_sequencer_if.sv
// rtl/vector_list_sequencer_if.sv - command memory and line drawer signals of the sequencer
interface vector_list_sequencer_if #(
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]    cmd_addr;
  logic                     cmd_rd;
  logic [2+2*OUT_WIDTH-1:0] cmd_data;
  logic                     draw_done;
  logic                     pos;
  logic                     draw;
  logic [OUT_WIDTH-1:0]     x_start;
  logic [OUT_WIDTH-1:0]     y_start;
  logic [OUT_WIDTH-1:0]     x_end;
  logic [OUT_WIDTH-1:0]     y_end;

  modport master (
    output cmd_addr, cmd_rd, pos, draw, x_start, y_start, x_end, y_end,
    input  cmd_data, draw_done
  );

  modport slave (
    input  cmd_addr, cmd_rd, pos, draw, x_start, y_start, x_end, y_end,
    output cmd_data, draw_done
  );
endinterface

// File: rtl/vector_clamp.sv
// rtl/vector_clamp.sv - signed offset add with saturation to the frame range
module vector_clamp #(
  parameter int OUT_WIDTH = 8,
  parameter int FRAME_MIN = 0,
  parameter int FRAME_MAX = 255
) (
  input  logic [OUT_WIDTH-1:0]        coord,
  input  logic signed [OUT_WIDTH:0]   off,
  output logic [OUT_WIDTH-1:0]        result
);
  localparam logic signed [OUT_WIDTH+1:0] LO = (OUT_WIDTH+2)'(FRAME_MIN);
  localparam logic signed [OUT_WIDTH+1:0] HI = (OUT_WIDTH+2)'(FRAME_MAX);

  logic signed [OUT_WIDTH+1:0] sum;

  assign sum = $signed({2'b00, coord}) + $signed({off[OUT_WIDTH], off});

  always_comb begin
    if (sum < LO)      result = LO[OUT_WIDTH-1:0];
    else if (sum > HI) result = HI[OUT_WIDTH-1:0];
    else               result = sum[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/vector_list_sequencer.sv
// rtl/vector_list_sequencer.sv - walks the per-frame vector list and issues pos/draw requests
// VECTOR_OFFSET_EN adds signed x_off/y_off inputs applied to endpoints with frame clamping.
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FRAME_MIN  = 0,
  parameter int FRAME_MAX  = 255,
  parameter int MAX_WAIT   = 4095
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enabled,
  input  logic                      frame_start,
`ifdef VECTOR_OFFSET_EN
  input  logic signed [OUT_WIDTH:0] x_off,
  input  logic signed [OUT_WIDTH:0] y_off,
`endif
  vector_list_sequencer_if.master   bus,
  output logic                      frame_busy,
  output logic                      frame_done,
  output logic                      timeout_err
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [OUT_WIDTH-1:0]  COORD_MIN = OUT_WIDTH'(FRAME_MIN);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  seq_state_e state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic rd_q, rd_n, pos_q, pos_n, draw_q, draw_n;
  logic busy_q, busy_n, done_q, done_n, terr_q, terr_n;
  logic [OUT_WIDTH-1:0] xs_q, xs_n, ys_q, ys_n, xe_q, xe_n, ye_q, ye_n;
  logic [OUT_WIDTH-1:0] cx_q, cx_n, cy_q, cy_n;
  logic [WAIT_W-1:0] wcnt_q, wcnt_n;

  opcode_e op;
  logic [OUT_WIDTH-1:0] cmd_x, cmd_y, ep_x, ep_y;

  assign op    = opcode_e'(bus.cmd_data[2*OUT_WIDTH +: 2]);
  assign cmd_x = bus.cmd_data[OUT_WIDTH +: OUT_WIDTH];
  assign cmd_y = bus.cmd_data[0 +: OUT_WIDTH];

`ifdef VECTOR_OFFSET_EN
  vector_clamp #(.OUT_WIDTH(OUT_WIDTH), .FRAME_MIN(FRAME_MIN), .FRAME_MAX(FRAME_MAX)) u_clamp_x (
    .coord(cmd_x), .off(x_off), .result(ep_x)
  );
  vector_clamp #(.OUT_WIDTH(OUT_WIDTH), .FRAME_MIN(FRAME_MIN), .FRAME_MAX(FRAME_MAX)) u_clamp_y (
    .coord(cmd_y), .off(y_off), .result(ep_y)
  );
`else
  // Without offsets nothing can leave the frame, so the upper bound is never consulted.
  logic [OUT_WIDTH-1:0] unused_frame_max;
  assign unused_frame_max = OUT_WIDTH'(FRAME_MAX);
  assign ep_x = cmd_x;
  assign ep_y = cmd_y;
`endif

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    rd_n    = 1'b0;
    pos_n   = 1'b0;
    draw_n  = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    terr_n  = terr_q;
    xs_n    = xs_q;
    ys_n    = ys_q;
    xe_n    = xe_q;
    ye_n    = ye_q;
    cx_n    = cx_q;
    cy_n    = cy_q;
    wcnt_n  = '0;
    case (state)
      S_IDLE: begin
        if (frame_start && enabled) begin
          state_n = S_FETCH;
          addr_n  = '0;
          busy_n  = 1'b1;
          terr_n  = 1'b0;
        end
      end
      S_FETCH: begin
        if (rd_q) state_n = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_NOP: begin
            if (addr_q == LAST_ADDR) state_n = S_FRAME_END;
            else begin
              addr_n  = addr_q + 1'b1;
              state_n = S_FETCH;
            end
          end
          OP_POS, OP_DRAW: begin
            xs_n    = cx_q;
            ys_n    = cy_q;
            xe_n    = ep_x;
            ye_n    = ep_y;
            cx_n    = ep_x;
            cy_n    = ep_y;
            pos_n   = (op == OP_POS);
            draw_n  = (op == OP_DRAW);
            state_n = S_WAIT_DONE;
          end
          default: state_n = S_FRAME_END;
        endcase
      end
      S_WAIT_DONE: begin
        // A completion arriving on the expiry cycle is honoured rather than flagged.
        if (bus.draw_done) begin
          if (addr_q == LAST_ADDR) state_n = S_FRAME_END;
          else begin
            addr_n  = addr_q + 1'b1;
            state_n = S_FETCH;
          end
        end else if (wcnt_q == WAIT_W'(MAX_WAIT - 1)) begin
          terr_n  = 1'b1;
          state_n = S_FRAME_END;
        end else begin
          wcnt_n = wcnt_q + 1'b1;
        end
      end
      S_FRAME_END: state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    // Read is issued in the first enabled FETCH cycle so data lands for DECODE.
    rd_n = (state_n == S_FETCH) && enabled;
    if (state_n == S_FRAME_END) begin
      done_n = 1'b1;
      busy_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
      rd_q   <= 1'b0;
      pos_q  <= 1'b0;
      draw_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      terr_q <= 1'b0;
      xs_q   <= COORD_MIN;
      ys_q   <= COORD_MIN;
      xe_q   <= COORD_MIN;
      ye_q   <= COORD_MIN;
      cx_q   <= COORD_MIN;
      cy_q   <= COORD_MIN;
      wcnt_q <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      rd_q   <= rd_n;
      pos_q  <= pos_n;
      draw_q <= draw_n;
      busy_q <= busy_n;
      done_q <= done_n;
      terr_q <= terr_n;
      xs_q   <= xs_n;
      ys_q   <= ys_n;
      xe_q   <= xe_n;
      ye_q   <= ye_n;
      cx_q   <= cx_n;
      cy_q   <= cy_n;
      wcnt_q <= wcnt_n;
    end
  end

  assign bus.cmd_addr = addr_q;
  assign bus.cmd_rd   = rd_q;
  assign bus.pos      = pos_q;
  assign bus.draw     = draw_q;
  assign bus.x_start  = xs_q;
  assign bus.y_start  = ys_q;
  assign bus.x_end    = xe_q;
  assign bus.y_end    = ye_q;
  assign frame_busy   = busy_q;
  assign frame_done   = done_q;
  assign timeout_err  = terr_q;
endmodule

// File: tb/tb_vector_list_sequencer.sv
// tb/tb_vector_list_sequencer.sv - directed self-checking bench for vector_list_sequencer
module tb_vector_list_sequencer;
  import vector_pkg::*;

  localparam int OW = 8;
  localparam int AW = 8;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enabled = 1'b0;
  logic frame_start = 1'b0;
  logic frame_busy, frame_done, timeout_err;
`ifdef VECTOR_OFFSET_EN
  logic signed [OW:0] x_off = '0;
  logic signed [OW:0] y_off = '0;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rd_count = 0;
  int drawer_delay = 5;
  int dd_cnt = 0;
  vector_cmd_t mem [0:(1<<AW)-1];

  vector_list_sequencer_if #(.OUT_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

  vector_list_sequencer #(
    .OUT_WIDTH(OW), .ADDR_WIDTH(AW), .FRAME_MIN(0), .FRAME_MAX(255), .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enabled(enabled),
    .frame_start(frame_start),
`ifdef VECTOR_OFFSET_EN
    .x_off(x_off),
    .y_off(y_off),
`endif
    .bus(bus),
    .frame_busy(frame_busy),
    .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cmd_rd) begin
      rd_count     <= rd_count + 1;
      bus.cmd_data <= mem[bus.cmd_addr];
    end
  end

  always @(posedge clk) begin
    bus.draw_done <= 1'b0;
    if (rst) dd_cnt <= 0;
    else if ((bus.pos || bus.draw) && drawer_delay > 0) dd_cnt <= drawer_delay - 1;
    else if (dd_cnt > 0) begin
      dd_cnt <= dd_cnt - 1;
      if (dd_cnt == 1) bus.draw_done <= 1'b1;
    end
  end

  function automatic vector_cmd_t mk(opcode_e op, int x, int y);
    vector_cmd_t c;
    c.op = op;
    c.x  = x[OW-1:0];
    c.y  = y[OW-1:0];
    return c;
  endfunction

  task automatic fill_mem(input opcode_e op);
    for (int i = 0; i < (1 << AW); i++) mem[i] = mk(op, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_frame(output int t0);
    @(negedge clk);
    frame_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_strobe(input int limit, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.pos || bus.draw) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(input int limit, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int r0;
    rst = 1'b1;
    enabled = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_rd, bus.pos, bus.draw, frame_busy, frame_done, timeout_err} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {bus.cmd_rd, bus.pos, bus.draw, frame_busy, frame_done, timeout_err});
    else passes++;
    checks++;
    if ({bus.x_start, bus.y_start, bus.x_end, bus.y_end, bus.cmd_addr} !== 40'h0)
      $display("FAIL reset_coords got %h want 0", {bus.x_start, bus.y_start, bus.x_end, bus.y_end, bus.cmd_addr});
    else passes++;
    rst = 1'b0;
    r0 = rd_count;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (frame_busy !== 1'b0 || rd_count != r0)
      $display("FAIL start_while_disabled busy=%b reads=%0d want busy=0 reads=0", frame_busy, rd_count - r0);
    else passes++;
  endtask

  task automatic test_two_cmd_list();
    int t0, t1, t2, t3, r0;
    bit ok;
    fill_mem(OP_END);
    mem[0] = mk(OP_POS, 10, 20);
    mem[1] = mk(OP_DRAW, 50, 60);
    drawer_delay = 5;
    enabled = 1'b1;
    r0 = rd_count;
    start_frame(t0);
    checks++;
    if (frame_busy !== 1'b1 || bus.cmd_rd !== 1'b1 || bus.cmd_addr !== 8'd0)
      $display("FAIL start_accept busy=%b rd=%b addr=%0d want 1 1 0", frame_busy, bus.cmd_rd, bus.cmd_addr);
    else passes++;
    wait_strobe(10, t1, ok);
    checks++;
    if (!ok || bus.pos !== 1'b1 || bus.draw !== 1'b0 || t1 - t0 != 3)
      $display("FAIL pos_strobe seen=%0d pos=%b latency=%0d want seen pos=1 latency=3", ok, bus.pos, t1 - t0);
    else passes++;
    checks++;
    if ({bus.x_start, bus.y_start, bus.x_end, bus.y_end} !== {8'd0, 8'd0, 8'd10, 8'd20})
      $display("FAIL pos_coords got %h want 00000a14", {bus.x_start, bus.y_start, bus.x_end, bus.y_end});
    else passes++;
    @(negedge clk);
    frame_start = 1'b1;
    checks++;
    if (bus.pos !== 1'b0) $display("FAIL pos_one_cycle pos=%b want 0", bus.pos);
    else passes++;
    @(negedge clk);
    frame_start = 1'b0;
    wait_strobe(20, t2, ok);
    checks++;
    if (!ok || bus.draw !== 1'b1 || t2 - t1 != 8)
      $display("FAIL draw_strobe seen=%0d draw=%b gap=%0d want seen draw=1 gap=8", ok, bus.draw, t2 - t1);
    else passes++;
    checks++;
    if ({bus.x_start, bus.y_start, bus.x_end, bus.y_end} !== {8'd10, 8'd20, 8'd50, 8'd60})
      $display("FAIL draw_coords got %h want 0a14323c", {bus.x_start, bus.y_start, bus.x_end, bus.y_end});
    else passes++;
    @(negedge clk);
    checks++;
    if (bus.draw !== 1'b0 || {bus.x_start, bus.y_start, bus.x_end, bus.y_end} !== {8'd10, 8'd20, 8'd50, 8'd60})
      $display("FAIL draw_hold draw=%b coords=%h want 0 0a14323c", bus.draw, {bus.x_start, bus.y_start, bus.x_end, bus.y_end});
    else passes++;
    wait_done(20, t3, ok);
    checks++;
    if (!ok || t3 - t2 != 8 || frame_busy !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL frame_end seen=%0d gap=%0d busy=%b terr=%b want seen gap=8 busy=0 terr=0", ok, t3 - t2, frame_busy, timeout_err);
    else passes++;
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || rd_count - r0 != 3)
      $display("FAIL read_count done=%b reads=%0d want done=0 reads=3", frame_done, rd_count - r0);
    else passes++;
  endtask

  task automatic test_nop_skip();
    int t0, t1, t2, r0;
    bit ok;
    do_reset();
    fill_mem(OP_END);
    mem[0] = mk(OP_NOP, 0, 0);
    mem[1] = mk(OP_NOP, 0, 0);
    mem[2] = mk(OP_DRAW, 255, 0);
    r0 = rd_count;
    start_frame(t0);
    wait_strobe(30, t1, ok);
    checks++;
    if (!ok || bus.draw !== 1'b1 || t1 - t0 != 7)
      $display("FAIL nop_draw_strobe seen=%0d draw=%b latency=%0d want seen draw=1 latency=7", ok, bus.draw, t1 - t0);
    else passes++;
    checks++;
    if ({bus.x_start, bus.y_start, bus.x_end, bus.y_end} !== {8'd0, 8'd0, 8'd255, 8'd0})
      $display("FAIL nop_draw_coords got %h want 0000ff00", {bus.x_start, bus.y_start, bus.x_end, bus.y_end});
    else passes++;
    wait_done(30, t2, ok);
    checks++;
    if (!ok || rd_count - r0 != 4)
      $display("FAIL nop_reads seen=%0d reads=%0d want seen reads=4", ok, rd_count - r0);
    else passes++;
  endtask

  task automatic test_timeout();
    int t0, t1, t2;
    bit ok;
    fill_mem(OP_END);
    mem[0] = mk(OP_DRAW, 5, 5);
    drawer_delay = 0;
    start_frame(t0);
    wait_strobe(10, t1, ok);
    wait_done(40, t2, ok);
    checks++;
    if (!ok || t2 - t1 != MW || timeout_err !== 1'b1 || frame_busy !== 1'b0)
      $display("FAIL timeout seen=%0d delay=%0d terr=%b busy=%b want seen delay=%0d terr=1 busy=0", ok, t2 - t1, timeout_err, frame_busy, MW);
    else passes++;
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky terr=%b want 1", timeout_err);
    else passes++;
    drawer_delay = 5;
    start_frame(t0);
    checks++;
    if (timeout_err !== 1'b0 || frame_busy !== 1'b1)
      $display("FAIL timeout_clear terr=%b busy=%b want 0 1", timeout_err, frame_busy);
    else passes++;
    wait_done(40, t2, ok);
    checks++;
    if (!ok || timeout_err !== 1'b0) $display("FAIL clean_frame seen=%0d terr=%b want seen terr=0", ok, timeout_err);
    else passes++;
  endtask

  task automatic test_expiry_tie();
    int t0, t1, t2;
    bit ok;
    fill_mem(OP_END);
    mem[0] = mk(OP_DRAW, 1, 2);
    drawer_delay = MW - 1;
    start_frame(t0);
    wait_strobe(10, t1, ok);
    repeat (MW) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || bus.cmd_rd !== 1'b1 || bus.cmd_addr !== 8'd1)
      $display("FAIL expiry_tie terr=%b rd=%b addr=%0d want 0 1 1", timeout_err, bus.cmd_rd, bus.cmd_addr);
    else passes++;
    wait_done(20, t2, ok);
    checks++;
    if (!ok || timeout_err !== 1'b0) $display("FAIL expiry_tie_end seen=%0d terr=%b want seen terr=0", ok, timeout_err);
    else passes++;
    drawer_delay = 5;
  endtask

  task automatic test_enable_stall();
    int t0, t1, t2, r0;
    bit ok, saw_rd;
    fill_mem(OP_END);
    mem[0] = mk(OP_POS, 30, 40);
    mem[1] = mk(OP_DRAW, 70, 80);
    r0 = rd_count;
    start_frame(t0);
    wait_strobe(10, t1, ok);
    enabled = 1'b0;
    saw_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmd_rd) saw_rd = 1'b1;
    end
    checks++;
    if (saw_rd || bus.cmd_addr !== 8'd1 || {bus.x_end, bus.y_end} !== {8'd30, 8'd40})
      $display("FAIL stall saw_rd=%0d addr=%0d end=%h want 0 1 1e28", saw_rd, bus.cmd_addr, {bus.x_end, bus.y_end});
    else passes++;
    enabled = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_rd !== 1'b1 || bus.cmd_addr !== 8'd1)
      $display("FAIL resume rd=%b addr=%0d want 1 1", bus.cmd_rd, bus.cmd_addr);
    else passes++;
    wait_strobe(10, t2, ok);
    checks++;
    if (!ok || bus.draw !== 1'b1 || {bus.x_start, bus.y_start, bus.x_end, bus.y_end} !== {8'd30, 8'd40, 8'd70, 8'd80})
      $display("FAIL resume_draw seen=%0d coords=%h want seen 1e284650", ok, {bus.x_start, bus.y_start, bus.x_end, bus.y_end});
    else passes++;
    wait_done(30, t2, ok);
    checks++;
    if (!ok || rd_count - r0 != 3) $display("FAIL stall_reads seen=%0d reads=%0d want seen reads=3", ok, rd_count - r0);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int t0, t1;
    bit ok, saw_done;
    fill_mem(OP_END);
    mem[0] = mk(OP_POS, 100, 110);
    start_frame(t0);
    wait_strobe(10, t1, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_rd, bus.pos, bus.draw, frame_busy, frame_done, timeout_err} !== 6'b0 ||
        {bus.x_start, bus.y_start, bus.x_end, bus.y_end, bus.cmd_addr} !== 40'h0)
      $display("FAIL async_reset flags=%b coords=%h want 0 0", {bus.cmd_rd, bus.pos, bus.draw, frame_busy, frame_done, timeout_err},
               {bus.x_start, bus.y_start, bus.x_end, bus.y_end, bus.cmd_addr});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (frame_done || frame_busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) $display("FAIL reset_no_done saw_done_or_busy=1 want 0");
    else passes++;
  endtask

  task automatic test_address_end();
    int t0, t1, r0;
    bit ok;
    fill_mem(OP_NOP);
    r0 = rd_count;
    start_frame(t0);
    wait_done(1200, t1, ok);
    checks++;
    if (!ok || rd_count - r0 != (1 << AW) || timeout_err !== 1'b0)
      $display("FAIL address_end seen=%0d reads=%0d terr=%b want seen reads=%0d terr=0", ok, rd_count - r0, timeout_err, 1 << AW);
    else passes++;
  endtask

`ifdef VECTOR_OFFSET_EN
  task automatic test_offset();
    int t0, t1, t2;
    bit ok;
    do_reset();
    fill_mem(OP_END);
    mem[0] = mk(OP_DRAW, 250, 10);
    x_off = 9'sd20;
    y_off = -9'sd30;
    start_frame(t0);
    wait_strobe(10, t1, ok);
    checks++;
    if (!ok || {bus.x_start, bus.y_start, bus.x_end, bus.y_end} !== {8'd0, 8'd0, 8'd255, 8'd0})
      $display("FAIL offset_clamp seen=%0d coords=%h want seen 0000ff00", ok, {bus.x_start, bus.y_start, bus.x_end, bus.y_end});
    else passes++;
    wait_done(20, t2, ok);
    x_off = '0;
    y_off = '0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_two_cmd_list();
    test_nop_skip();
    test_timeout();
    test_expiry_tie();
    test_enable_stall();
    test_reset_mid_frame();
    test_address_end();
`ifdef VECTOR_OFFSET_EN
    test_offset();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
